// File: rtl/ta_arbiter_pkg.sv
// Shared definitions for the truncation-adder arbiter slice.
package ta_arb_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr, wrapping, and moves ptr
// just past the winner whenever a grant is issued.
module rr_arbiter
    import ta_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);
    logic [IDW-1:0] ptr;
    logic           found;
    int unsigned    idx;

    // Pick the first requester at or after ptr.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (advance && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    // Advance the priority pointer past each winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/trunc_adder.sv
// Truncation adder: the BORDER LSBs of the sum are forced to zero and the
// operand LSBs are ignored; the upper bits are added exactly with carry-out.
module trunc_adder #(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned BORDER   = 2,
    parameter int unsigned SUBTYPE  = 1
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    output logic [BITWIDTH:0]   sum
);
    localparam int unsigned W = BITWIDTH - BORDER;

    logic [W-1:0] ah, bh, g, p;
    logic [W:0]   c;
    logic         unused_lsb;

    assign ah         = a[BITWIDTH-1:BORDER];
    assign bh         = b[BITWIDTH-1:BORDER];
    assign g          = ah & bh;
    assign p          = ah ^ bh;
    assign unused_lsb = ^{a[BORDER-1:0], b[BORDER-1:0]};

    generate
        if (SUBTYPE == 0) begin : g_rca
            // Ripple-carry chain through the accurate region.
            always_comb begin
                c[0] = 1'b0;
                for (int unsigned i = 0; i < W; i++) begin
                    c[i+1] = g[i] | (p[i] & c[i]);
                end
            end
        end else begin : g_cla
            logic term;
            // Carry-lookahead: each carry is a flat sum of generate/propagate products.
            always_comb begin
                c    = '0;
                term = 1'b0;
                for (int unsigned i = 0; i < W; i++) begin
                    for (int unsigned j = 0; j <= i; j++) begin
                        term = g[j];
                        for (int unsigned k = j + 1; k <= i; k++) begin
                            term = term & p[k];
                        end
                        c[i+1] = c[i+1] | term;
                    end
                end
            end
        end
    endgenerate

    assign sum = {c[W], p ^ c[W-1:0], {BORDER{1'b0}}};

endmodule

// File: rtl/ta_arbiter.sv
// Shares one truncation adder between NREQ requesters via round-robin
// arbitration, with a single registered result stage.
module ta_arbiter
    import ta_arb_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned BITWIDTH = 8,
    parameter  int unsigned BORDER   = 2,
    parameter  int unsigned SUBTYPE  = 1,
    localparam int unsigned IDW      = id_width(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITWIDTH-1:0] req_a,
    input  logic [NREQ*BITWIDTH-1:0] req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITWIDTH:0]        out_sum,
    output logic [IDW-1:0]           out_id,
    output logic [CNT_W-1:0]         out_cnt
);
    out_state_t          state;
    logic                can_accept;
    logic                advance;
    logic                accept;
    logic [IDW-1:0]      grant_id;
    logic [BITWIDTH-1:0] a_sel, b_sel;
    logic [BITWIDTH:0]   sum;

    assign can_accept = !out_valid || out_ready;
    assign advance    = can_accept && !rst;
    assign accept     = |req_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (advance),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

    assign a_sel = req_a[grant_id*BITWIDTH +: BITWIDTH];
    assign b_sel = req_b[grant_id*BITWIDTH +: BITWIDTH];

    trunc_adder #(
        .BITWIDTH (BITWIDTH),
        .BORDER   (BORDER),
        .SUBTYPE  (SUBTYPE)
    ) u_add (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

    // Output-register FSM: load on accept, empty on a drain with no refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                        out_sum   <= sum;
                        out_id    <= grant_id;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        out_sum <= sum;
                        out_id  <= grant_id;
                    end else if (out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count delivered results; wraps naturally at 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (out_valid && out_ready) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ta_arbiter.sv
// Scoreboard bench for ta_arbiter: a behavioural model predicts grants and
// queues expected results; directed tasks cover the named scenarios.
module tb_ta_arbiter;
    import ta_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int BW   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic        out_ready;

    logic [3:0]  req_ready, req_ready_r;
    logic        out_valid, out_valid_r;
    logic [8:0]  out_sum, out_sum_r;
    logic [1:0]  out_id, out_id_r;
    logic [15:0] out_cnt, out_cnt_r;

    always #5 clk = ~clk;

    ta_arbiter #(.NREQ(NREQ), .BITWIDTH(BW), .BORDER(2), .SUBTYPE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .out_cnt(out_cnt)
    );

    ta_arbiter #(.NREQ(NREQ), .BITWIDTH(BW), .BORDER(2), .SUBTYPE(0)) dut_rca (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready_r), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_sum(out_sum_r), .out_id(out_id_r), .out_cnt(out_cnt_r)
    );

    typedef struct packed {
        logic [8:0] sum;
        logic [1:0] id;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    bit          m_valid = 1'b0;
    int          m_ptr = 0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_grant;
    int          m_gid;

    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        logic [6:0] h;
        h = {1'b0, a[7:2]} + {1'b0, b[7:2]};
        return {h, 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        req_a = $urandom;
        req_b = $urandom;
    endtask

    // Model: predict grant, check handshake/valid, pop on drain, push on accept.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (out_valid !== m_valid || out_valid_r !== m_valid) begin
                bad++;
                $display("FAIL mon_valid: got %0b/%0b want %0b", out_valid, out_valid_r, m_valid);
            end
            m_grant = '0;
            m_gid   = -1;
            if (!rst && (!m_valid || out_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (m_gid < 0 && req_valid[idx]) begin
                        m_gid         = idx;
                        m_grant[idx]  = 1'b1;
                    end
                end
            end
            total++;
            if (req_ready !== m_grant || req_ready_r !== m_grant) begin
                bad++;
                $display("FAIL mon_ready: got %b/%b want %b", req_ready, req_ready_r, m_grant);
            end
            if (rst) begin
                sb.delete();
                m_valid = 1'b0;
                m_ptr   = 0;
                m_cnt   = '0;
            end else begin
                if (m_valid && out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL mon_underflow: drain with empty scoreboard");
                    end else begin
                        e = sb.pop_front();
                        if (out_sum !== e.sum || out_sum_r !== e.sum || out_id !== e.id ||
                            out_cnt !== m_cnt) begin
                            bad++;
                            $display("FAIL mon_result: got sum=%h rca=%h id=%0d cnt=%h want sum=%h id=%0d cnt=%h",
                                     out_sum, out_sum_r, out_id, out_cnt, e.sum, e.id, m_cnt);
                        end
                    end
                    m_cnt   = m_cnt + 16'd1;
                    m_valid = 1'b0;
                end
                if (m_gid >= 0) begin
                    sb.push_back(exp_t'{sum: ref_sum(req_a[m_gid*8 +: 8], req_b[m_gid*8 +: 8]),
                                        id: 2'(m_gid)});
                    m_ptr   = (m_gid + 1) % NREQ;
                    m_valid = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        rand_ops();
        step();
        mon_en = 1'b1;
        step();
        total++;
        if ({out_valid, out_sum, out_id, out_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_vals: got v=%0b sum=%h id=%0d cnt=%h want all zero",
                     out_valid, out_sum, out_id, out_cnt);
        end
        #2;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        rst       = 1'b0;
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_arith();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [8:0] te [3];
        ta = '{8'h5F, 8'hFF, 8'h03};
        tb = '{8'h23, 8'hFF, 8'h03};
        te = '{9'h07C, 9'h1F8, 9'h000};
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            req_a[15:8] = ta[i];
            req_b[15:8] = tb[i];
            req_valid   = 4'b0010;
            out_ready   = 1'b1;
            step();
            req_valid = 4'b0000;
            rand_ops();
            total++;
            if (out_valid !== 1'b1 || out_sum !== te[i] || out_sum_r !== te[i] || out_id !== 2'd1) begin
                bad++;
                $display("FAIL arith_%0d: got v=%0b sum=%h rca=%h id=%0d want v=1 sum=%h id=1",
                         i, out_valid, out_sum, out_sum_r, out_id, te[i]);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ids [6];
        logic [15:0] prev;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        prev    = '0;
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step();
            total++;
            if (out_id !== exp_ids[i] || (i > 0 && out_cnt !== prev + 16'd1)) begin
                bad++;
                $display("FAIL rr_%0d: got id=%0d cnt=%h want id=%0d cnt=%h",
                         i, out_id, out_cnt, exp_ids[i], prev + 16'd1);
            end
            prev = out_cnt;
        end
    endtask

    task automatic test_backpressure();
        logic [8:0]  fs;
        logic [1:0]  fi;
        logic [15:0] fc;
        fs = out_sum;
        fi = out_id;
        fc = out_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            #2;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready_%0d: got %b want 0000", i, req_ready);
            end
            step();
            total++;
            if (out_valid !== 1'b1 || out_sum !== fs || out_id !== fi || out_cnt !== fc) begin
                bad++;
                $display("FAIL bp_hold_%0d: got v=%0b sum=%h id=%0d cnt=%h want v=1 sum=%h id=%0d cnt=%h",
                         i, out_valid, out_sum, out_id, out_cnt, fs, fi, fc);
            end
        end
        out_ready = 1'b1;
        #2;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 0100", req_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_cnt !== fc + 16'd1) begin
            bad++;
            $display("FAIL bp_release: got v=%0b id=%0d cnt=%h want v=1 id=2 cnt=%h",
                     out_valid, out_id, out_cnt, fc + 16'd1);
        end
        fs = out_sum;
        fi = out_id;
        req_valid = 4'h0;
        step();
        total++;
        if (out_valid !== 1'b0 || out_sum !== fs || out_id !== fi) begin
            bad++;
            $display("FAIL idle_keep: got v=%0b sum=%h id=%0d want v=0 sum=%h id=%0d",
                     out_valid, out_sum, out_id, fs, fi);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_ids [4];
        exp_ids = '{2'd0, 2'd3, 2'd0, 2'd3};
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1000;
        rand_ops();
        step();
        total++;
        if (out_id !== 2'd3) begin
            bad++;
            $display("FAIL fair_seed: got id=%0d want 3", out_id);
        end
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            step();
            total++;
            if (out_id !== exp_ids[i]) begin
                bad++;
                $display("FAIL fair_%0d: got id=%0d want %0d", i, out_id, exp_ids[i]);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        total++;
        if (out_valid !== 1'b1 || out_cnt !== 16'd7) begin
            bad++;
            $display("FAIL rmid_pre: got v=%0b cnt=%h want v=1 cnt=0007", out_valid, out_cnt);
        end
        rst = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || out_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rmid_post: got v=%0b cnt=%h want v=0 cnt=0000", out_valid, out_cnt);
        end
        rst       = 1'b0;
        req_valid = 4'b1010;
        #2;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL rmid_grant: got %b want 0010", req_ready);
        end
        step();
        total++;
        if (out_id !== 2'd1) begin
            bad++;
            $display("FAIL rmid_id: got id=%0d want 1", out_id);
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_cnt_wrap();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 65536; i++) begin
            rand_ops();
            step();
        end
        total++;
        if (out_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_ffff: got cnt=%h want ffff", out_cnt);
        end
        step();
        total++;
        if (out_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero: got cnt=%h want 0000", out_cnt);
        end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        test_reset();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_cnt_wrap();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
